// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_addr_stack
// Description : Hardware return-address stack for the single-cycle datapath.
//               JSB pushes the return PC; the return instruction pops it while
//               top_addr feeds the PC-source mux in the same cycle. Storage is
//               registered, the occupancy counter doubles as the stack pointer,
//               and overflow/underflow are sticky until clear_err.
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               push_stack - push request
//               pop_stack  - pop request
//               push_addr  - return address written on push
//               clear_err  - synchronous clear of sticky error flags
//               top_addr   - current top entry (0 when empty), combinational
//               count      - number of valid entries, 0..DEPTH
//               empty/full - occupancy status
//               overflow   - sticky, push refused while full
//               underflow  - sticky, pop while empty
// Options     : define RAS_WRAP_EN for a circular stack (push while full
//               overwrites the oldest entry instead of being refused).
// Revision    : 1.0 - initial release
// ============================================================================
module return_addr_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_stack,
  input  logic              pop_stack,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              clear_err,
  output logic [ADDR_W-1:0] top_addr,
  output logic [PTR_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_ONE   = PTR_W'(1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              w_empty, w_full;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_slot_idx;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == C_DEPTH);

`ifdef RAS_WRAP_EN
  // Circular mode: logical entry 0 lives at physical slot base_q.
  logic [IDX_W-1:0] base_q, base_d;

  assign w_top_idx  = base_q + IDX_W'(count_q - C_ONE);
  assign w_slot_idx = base_q + IDX_W'(count_q);
`else
  assign w_top_idx  = IDX_W'(count_q - C_ONE);
  assign w_slot_idx = IDX_W'(count_q);
`endif

  always_comb begin
    count_d     = count_q;
    // Error events below override the clear, so setting wins over clearing.
    overflow_d  = overflow_q  & ~clear_err;
    underflow_d = underflow_q & ~clear_err;
    w_wr_en     = 1'b0;
    w_wr_idx    = w_slot_idx;
`ifdef RAS_WRAP_EN
    base_d      = base_q;
`endif
    case ({push_stack, pop_stack})
      2'b10: begin
        if (!w_full) begin
          w_wr_en = 1'b1;
          count_d = count_q + C_ONE;
        end else begin
`ifdef RAS_WRAP_EN
          // When full the next slot aliases the oldest entry; overwrite it
          // and slide the base so the window keeps the newest DEPTH entries.
          w_wr_en = 1'b1;
          base_d  = base_q + IDX_W'(1);
`else
          overflow_d = 1'b1;
`endif
        end
      end
      2'b01: begin
        if (!w_empty) count_d = count_q - C_ONE;
        else          underflow_d = 1'b1;
      end
      2'b11: begin
        w_wr_en = 1'b1;
        if (!w_empty) begin
          // Replace the top in place; legal even when full.
          w_wr_idx = w_top_idx;
        end else begin
          // Empty: behaves as a push, but the pop half still underflows.
          count_d     = C_ONE;
          underflow_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef RAS_WRAP_EN
      base_q      <= '0;
`endif
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef RAS_WRAP_EN
      base_q      <= base_d;
`endif
    end
  end

  // Storage is deliberately not reset; it is invisible while count is zero.
  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[w_wr_idx] <= push_addr;
  end

  assign top_addr  = w_empty ? '0 : mem_q[w_top_idx];
  assign count     = count_q;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_return_addr_stack
// Description : Directed self-checking bench for return_addr_stack with
//               hand-computed expectations (both RAS_WRAP_EN settings).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_return_addr_stack;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              push_stack;
  logic              pop_stack;
  logic [ADDR_W-1:0] push_addr;
  logic              clear_err;
  logic [ADDR_W-1:0] top_addr;
  logic [PTR_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  int checks   = 0;
  int failures = 0;

  return_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_stack (push_stack),
    .pop_stack  (pop_stack),
    .push_addr  (push_addr),
    .clear_err  (clear_err),
    .top_addr   (top_addr),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, take the edge, sample 1 ns later, then idle.
  task automatic step(input logic push, input logic pop,
                      input logic [ADDR_W-1:0] addr, input logic clr);
    push_stack = push;
    pop_stack  = pop;
    push_addr  = addr;
    clear_err  = clr;
    @(posedge clk);
    #1;
    push_stack = 1'b0;
    pop_stack  = 1'b0;
    clear_err  = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_top;
    rst_n = 1'b0; push_stack = 1'b0; pop_stack = 1'b0;
    push_addr = '0; clear_err = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full), 32'd0);
    check("rst_top",   32'(top_addr), 32'h000);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_unf",   32'(underflow), 32'd0);

    // Three pushes, then asynchronous reset between edges.
    @(posedge clk); #1;
    step(1'b1, 1'b0, 12'h101, 1'b0);
    step(1'b1, 1'b0, 12'h202, 1'b0);
    step(1'b1, 1'b0, 12'h303, 1'b0);
    check("push3_count", 32'(count), 32'd3);
    check("push3_top",   32'(top_addr), 32'h303);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_top",   32'(top_addr), 32'h000);
    rst_n = 1'b1;

    // Push three again, then pop with zero read latency.
    step(1'b1, 1'b0, 12'h101, 1'b0);
    step(1'b1, 1'b0, 12'h202, 1'b0);
    step(1'b1, 1'b0, 12'h303, 1'b0);
    pop_stack = 1'b1;
    #1;
    check("pop_top_before", 32'(top_addr), 32'h303);
    @(posedge clk); #1;
    pop_stack = 1'b0;
    check("pop_top_after", 32'(top_addr), 32'h202);
    check("pop_count",     32'(count), 32'd2);
    step(1'b0, 1'b1, 12'h000, 1'b0);
    check("pop2_top", 32'(top_addr), 32'h101);
    step(1'b0, 1'b1, 12'h000, 1'b0);
    check("drain_empty", 32'(empty), 32'd1);

    // Fill to DEPTH and push one more.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 12'(12'h010 + i), 1'b0);
    check("fill_full",  32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_top",   32'(top_addr), 32'h017);
    step(1'b1, 1'b0, 12'h0FF, 1'b0);
    check("extra_count", 32'(count), 32'd8);
    check("extra_full",  32'(full), 32'd1);
`ifdef RAS_WRAP_EN
    check("wrap_top", 32'(top_addr), 32'h0FF);
    check("wrap_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_top = (i == 0) ? 12'h0FF : 12'(12'h018 - i);
      check($sformatf("wrap_pop%0d", i), 32'(top_addr), 32'(exp_top));
      step(1'b0, 1'b1, 12'h000, 1'b0);
    end
`else
    check("ovf_top", 32'(top_addr), 32'h017);
    check("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      exp_top = 12'(12'h017 - i);
      check($sformatf("full_pop%0d", i), 32'(top_addr), 32'(exp_top));
      step(1'b0, 1'b1, 12'h000, 1'b0);
    end
`endif
    check("after_fill_empty", 32'(empty), 32'd1);
    check("after_fill_unf",   32'(underflow), 32'd0);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Underflow, clear, and set-wins-over-clear.
    step(1'b0, 1'b1, 12'h000, 1'b0);
    check("unf_set",   32'(underflow), 32'd1);
    check("unf_count", 32'(count), 32'd0);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    check("unf_clear", 32'(underflow), 32'd0);
    step(1'b0, 1'b1, 12'h000, 1'b1);
    check("unf_set_wins", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    check("unf_clear2", 32'(underflow), 32'd0);

    // Push+pop replaces the top; on empty it behaves as push plus underflow.
    step(1'b1, 1'b0, 12'h0AA, 1'b0);
    step(1'b1, 1'b1, 12'h0BB, 1'b0);
    check("repl_count", 32'(count), 32'd1);
    check("repl_top",   32'(top_addr), 32'h0BB);
    check("repl_ovf",   32'(overflow), 32'd0);
    check("repl_unf",   32'(underflow), 32'd0);
    step(1'b0, 1'b1, 12'h000, 1'b0);
    check("repl_drain", 32'(empty), 32'd1);
    step(1'b1, 1'b1, 12'h123, 1'b0);
    check("pp_empty_count", 32'(count), 32'd1);
    check("pp_empty_top",   32'(top_addr), 32'h123);
    check("pp_empty_unf",   32'(underflow), 32'd1);
    step(1'b0, 1'b1, 12'h000, 1'b1);
    check("pp_drain", 32'(empty), 32'd1);
    check("pp_clear", 32'(underflow), 32'd0);

    // Nested call/return sequence.
    step(1'b1, 1'b0, 12'h040, 1'b0);
    step(1'b1, 1'b0, 12'h080, 1'b0);
    check("nest_ret1", 32'(top_addr), 32'h080);
    step(1'b0, 1'b1, 12'h000, 1'b0);
    step(1'b1, 1'b0, 12'h0C0, 1'b0);
    check("nest_ret2", 32'(top_addr), 32'h0C0);
    step(1'b0, 1'b1, 12'h000, 1'b0);
    check("nest_ret3", 32'(top_addr), 32'h040);
    step(1'b0, 1'b1, 12'h000, 1'b0);
    check("nest_empty", 32'(empty), 32'd1);
    check("nest_flags", 32'({overflow, underflow}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack. It is the responder to the controller's push_stack/pop_stack requests.
- JSB pushes the return PC supplied by the datapath. The return instruction pops it, and top_addr feeds the stack input of the PC-source mux in the same cycle.
- Sits beside the PC register in the single-cycle datapath.
- Registered storage with a stack pointer, plus full/empty status and sticky error flags.

Parameters:
- ADDR_W, 12, width of a stored return address (PC width).
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push_stack  input  1  push request, sampled on the rising edge.
- pop_stack  input  1  pop request, sampled on the rising edge.
- push_addr  input  ADDR_W  return address to store on push.
- clear_err  input  1  synchronous clear of the sticky error flags.
- top_addr  output  ADDR_W  current top entry, combinational from storage; 0 when empty.
- count  output  PTR_W  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; set by a push refused while full.
- underflow  output  1  sticky; set by a pop while empty.

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - Asserting rst_n low immediately forces count=0, overflow=0, underflow=0, hence empty=1, full=0, top_addr=0.
  - Storage contents are not reset; they are unobservable while count==0.
  - Reset asserted mid-operation discards all entries.
- State: storage array mem[0..DEPTH-1]; count acts as the stack pointer. The next write slot is mem[count], and the top is mem[count-1].
- Read latency 0: top_addr reflects the top in the same cycle that pop_stack is asserted. This lets the PC mux take it before the edge.
- Write latency 1: a pushed value appears on top_addr the cycle after the push edge.
- Push only:
  - Not full: mem[count] <= push_addr, count <= count+1.
  - Full: no state change; overflow <= 1.
- Pop only:
  - Not empty: count <= count-1; storage unchanged.
  - Empty: no state change; underflow <= 1.
- Push and pop in the same cycle:
  - Not empty: replace the top. mem[count-1] <= push_addr; count unchanged; no flags, even when full.
  - Empty: treat as push only. mem[0] <= push_addr, count <= 1, underflow <= 1.
- Neither: hold.
- clear_err=1 clears overflow and underflow at the edge. If an error event happens in that same cycle, setting wins over clearing.
- Pointer arithmetic is unsigned, PTR_W bits wide. Storage index uses the low $clog2(DEPTH) bits. count never exceeds DEPTH and never goes below 0.
- Outputs empty, full and top_addr are pure functions of the registered state.

Optional Feature:
- Macro: RAS_WRAP_EN.
- Defined: the stack is circular.
  - A push while full overwrites the oldest entry and advances a base pointer; count stays DEPTH and overflow is not set.
  - The wrapped case of push+pop is unchanged (replace top).
  - Pops beyond DEPTH consecutive pushes return the most recent DEPTH addresses only.
- Undefined: behaviour exactly as above (refuse the push and set overflow). No base pointer logic is compiled.

Test Plan:
- Reset then idle → count=0, empty=1, top_addr=0x000, overflow=0, underflow=0. Assert rst_n low mid-stack with count=3 → count=0 at once, without waiting for an edge.
- Push 0x101, 0x202, 0x303 on three edges → count=3, top_addr=0x303. Pop → top_addr=0x303 before the edge and 0x202 after it; count=2.
- Push DEPTH=8 addresses 0x010..0x017, then push 0x0FF:
  - Macro off → full=1, count=8, top_addr=0x017, overflow=1.
  - Macro on → top_addr=0x0FF, overflow=0; eight pops return 0x0FF, 0x017..0x011.
- Pop while empty → underflow=1, count=0. Then clear_err=1 for one cycle → underflow=0. Pop while empty with clear_err=1 in the same cycle → underflow stays 1.
- Push 0x0AA; then push 0x0BB with pop in the same cycle → count=1, top_addr=0x0BB, no flags. Push+pop on an empty stack → count=1, top_addr=push_addr, underflow=1.
- Nested calls (push 0x040, push 0x080, pop, push 0x0C0, pop, pop) → pops return 0x080, 0x0C0, 0x040; final empty=1.
